irq_sequencer: RTL and testbench

- Upstream companion to the CPU control FSM; turns external reset, NMI and IRQ pins plus decoded BRK into a single committed interrupt request at instruction boundaries.
- Drives the request source, the vector address (FFFA/FFFC/FFFE) and the B-flag value the control FSM pushes.
- Holds the CPU off during the power-on/reset sequence, then issues the reset-vector request.
- Owns pin synchronisation, NMI edge latching, I-flag masking and priority so the control FSM only handles a one-cycle accept/done handshake.

---
 rtl/irq_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_irq_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// Interrupt request sequencer: synchronises NMI/IRQ pins, latches NMI edges, runs the
// power-on hold sequence and presents one prioritised request to the CPU control FSM.
module irq_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned RST_HOLD_CYCLES = 7,
  parameter logic [15:0] NMI_VEC         = 16'hFFFA,
  parameter logic [15:0] RST_VEC         = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC         = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        p_i,
  input  logic        brk_req,
  input  logic        boundary,
  input  logic        int_ack,
  input  logic        int_done,
  output logic        cpu_hold,
  output logic        int_pending,
  output logic [1:0]  int_src,
  output logic        rst_req,
  output logic [15:0] vec_addr,
  output logic        b_flag,
  output logic        in_service
);

  localparam int unsigned CntW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RST_HOLD_CYCLES - 1);

  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcIrq  = 2'd1;
  localparam logic [1:0] SrcBrk  = 2'd2;
  localparam logic [1:0] SrcNmi  = 2'd3;

  typedef enum logic [2:0] {
    StHold,
    StRstReq,
    StIdle,
    StReq,
    StSvc
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   nmi_prev_q;
  logic                   nmi_latch_q, nmi_latch_d;
  logic [1:0]             src_q, src_d;
  logic                   rst_req_q, rst_req_d;
  logic [15:0]            vec_q, vec_d;
  logic                   b_flag_q, b_flag_d;

  logic nmi_s;
  logic irq_s;
  logic nmi_fall;
  logic nmi_clr;

  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_fall = nmi_prev_q & ~nmi_s;

  // Pin synchronisers idle high so a reset never fabricates an NMI edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_n};
      nmi_prev_q <= nmi_s;
    end
  end

  // Set beats clear so an edge arriving on the acceptance cycle is kept.
  always_comb begin
    nmi_latch_d = nmi_latch_q;
    if (nmi_clr) begin
      nmi_latch_d = 1'b0;
    end
    if (nmi_fall) begin
      nmi_latch_d = 1'b1;
    end
    if (state_q == StHold) begin
      nmi_latch_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    rst_req_d = rst_req_q;
    vec_d     = vec_q;
    b_flag_d  = b_flag_q;
    nmi_clr   = 1'b0;

    case (state_q)
      StHold: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d   = StRstReq;
          cnt_d     = '0;
          src_d     = SrcNmi;
          rst_req_d = 1'b1;
          vec_d     = RST_VEC;
          b_flag_d  = 1'b0;
        end
      end

      StRstReq: begin
        if (int_ack) begin
          state_d = StSvc;
        end
      end

      StIdle: begin
        if (boundary) begin
          if (nmi_latch_q) begin
            state_d  = StReq;
            src_d    = SrcNmi;
            vec_d    = NMI_VEC;
            b_flag_d = 1'b0;
          end else if (brk_req) begin
            state_d  = StReq;
            src_d    = SrcBrk;
            vec_d    = IRQ_VEC;
            b_flag_d = 1'b1;
          end else if (!irq_s && !p_i) begin
            state_d  = StReq;
            src_d    = SrcIrq;
            vec_d    = IRQ_VEC;
            b_flag_d = 1'b0;
          end
        end
      end

      StReq: begin
        if (int_ack) begin
          state_d = StSvc;
          nmi_clr = (src_q == SrcNmi) && !rst_req_q;
        end
      end

      StSvc: begin
        // A coincident ack takes precedence, so done only counts on its own.
        if (int_done && !int_ack) begin
          state_d   = StIdle;
          src_d     = SrcNone;
          rst_req_d = 1'b0;
          b_flag_d  = 1'b0;
        end
      end

      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      nmi_latch_q <= 1'b0;
      src_q       <= SrcNone;
      rst_req_q   <= 1'b1;
      vec_q       <= RST_VEC;
      b_flag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nmi_latch_q <= nmi_latch_d;
      src_q       <= src_d;
      rst_req_q   <= rst_req_d;
      vec_q       <= vec_d;
      b_flag_q    <= b_flag_d;
    end
  end

  assign cpu_hold    = (state_q == StHold);
  assign int_pending = (state_q == StReq) || (state_q == StRstReq);
  assign in_service  = (state_q == StSvc);
  assign int_src     = src_q;
  assign rst_req     = rst_req_q;
  assign vec_addr    = vec_q;
  assign b_flag      = b_flag_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: expected output snapshots are queued with each stimulus
// step and compared against the DUT one cycle later.
module tb_irq_sequencer;

  localparam logic [15:0] VN = 16'hFFFA;
  localparam logic [15:0] VR = 16'hFFFC;
  localparam logic [15:0] VI = 16'hFFFE;

  typedef struct packed {
    logic        hold;
    logic        pend;
    logic [1:0]  src;
    logic        rst;
    logic [15:0] vec;
    logic        b;
    logic        svc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        nmi_n, irq_n, p_i, brk_req, boundary, int_ack, int_done;
  logic        cpu_hold, int_pending, rst_req, b_flag, in_service;
  logic [1:0]  int_src;
  logic [15:0] vec_addr;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_run  = 0;
  int    n_fail = 0;

  irq_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .p_i        (p_i),
    .brk_req    (brk_req),
    .boundary   (boundary),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .cpu_hold   (cpu_hold),
    .int_pending(int_pending),
    .int_src    (int_src),
    .rst_req    (rst_req),
    .vec_addr   (vec_addr),
    .b_flag     (b_flag),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic hold, logic pend, logic [1:0] src, logic rst,
                              logic [15:0] vec, logic b, logic svc);
    obs_t o;
    o = '{hold: hold, pend: pend, src: src, rst: rst, vec: vec, b: b, svc: svc};
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic chk();
    obs_t  e;
    obs_t  o;
    string t;
    n_run++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed no expectation, required one queued");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = mk(cpu_hold, int_pending, int_src, rst_req, vec_addr, b_flag, in_service);
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed hold=%0b pend=%0b src=%0d rst=%0b vec=%h b=%0b svc=%0b, expected hold=%0b pend=%0b src=%0d rst=%0b vec=%h b=%0b svc=%0b",
             t, o.hold, o.pend, o.src, o.rst, o.vec, o.b, o.svc,
             e.hold, e.pend, e.src, e.rst, e.vec, e.b, e.svc);
    end
  endtask

  // Called right after reset is released: 7 hold cycles then the reset-vector request.
  task automatic hold_sequence(input string t);
    for (int i = 0; i < 7; i++) begin
      push(t, mk(1, 0, 0, 1, VR, 0, 0));
      chk();
      step();
    end
    push({t, "_rst_req"}, mk(0, 1, 3, 1, VR, 0, 0));
    chk();
  endtask

  initial begin
    reset = 1'b1;
    nmi_n = 1'b1; irq_n = 1'b1; p_i = 1'b1; brk_req = 1'b0;
    boundary = 1'b0; int_ack = 1'b0; int_done = 1'b0;

    // Power-on reset and the reset-vector handshake
    repeat (3) @(posedge clk);
    #1;
    push("reset_state", mk(1, 0, 0, 1, VR, 0, 0));
    chk();
    reset = 1'b0;
    hold_sequence("por_hold");
    push("rst_boundary_ignored", mk(0, 1, 3, 1, VR, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    push("rst_svc", mk(0, 0, 3, 1, VR, 0, 1));
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk();
    push("rst_done", mk(0, 0, 0, 0, VR, 0, 0));
    int_done = 1'b1; step(); int_done = 1'b0;
    chk();

    // IRQ masked by I, then taken; deasserting irq_n after commit does not cancel it
    irq_n = 1'b0; p_i = 1'b1;
    repeat (3) step();
    push("irq_masked", mk(0, 0, 0, 0, VR, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    p_i = 1'b0;
    push("irq_req", mk(0, 1, 1, 0, VI, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    irq_n = 1'b1; p_i = 1'b1;
    push("irq_frozen", mk(0, 1, 1, 0, VI, 0, 0));
    step();
    chk();
    push("irq_svc", mk(0, 0, 1, 0, VI, 0, 1));
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk();
    push("irq_done", mk(0, 0, 0, 0, VI, 0, 0));
    int_done = 1'b1; step(); int_done = 1'b0;
    chk();

    // NMI beats a pending IRQ; a held-low NMI pin yields only one request
    nmi_n = 1'b0; irq_n = 1'b0; p_i = 1'b0;
    repeat (3) step();
    push("nmi_prio", mk(0, 1, 3, 0, VN, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    push("nmi_svc", mk(0, 0, 3, 0, VN, 0, 1));
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk();
    push("nmi_done", mk(0, 0, 0, 0, VN, 0, 0));
    int_done = 1'b1; step(); int_done = 1'b0;
    chk();
    push("irq_after_nmi", mk(0, 1, 1, 0, VI, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    push("irq_after_nmi_done", mk(0, 0, 0, 0, VI, 0, 0));
    int_done = 1'b1; step(); int_done = 1'b0;
    chk();
    irq_n = 1'b1; nmi_n = 1'b1;
    repeat (4) step();

    // BRK ignores the I flag and pushes B=1
    p_i = 1'b1; brk_req = 1'b1;
    push("brk_req", mk(0, 1, 2, 0, VI, 1, 0));
    boundary = 1'b1; step(); boundary = 1'b0; brk_req = 1'b0;
    chk();
    push("brk_svc", mk(0, 0, 2, 0, VI, 1, 1));
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk();
    push("brk_done", mk(0, 0, 0, 0, VI, 0, 0));
    int_done = 1'b1; step(); int_done = 1'b0;
    chk();
    push("no_stray_req", mk(0, 0, 0, 0, VI, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();

    // Second NMI edge detected on the same cycle the first NMI is acknowledged
    nmi_n = 1'b0; step();
    nmi_n = 1'b1; step();
    nmi_n = 1'b0; step();
    push("nmi1_req", mk(0, 1, 3, 0, VN, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    push("nmi1_svc", mk(0, 0, 3, 0, VN, 0, 1));
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk();
    push("nmi1_done", mk(0, 0, 0, 0, VN, 0, 0));
    int_done = 1'b1; step(); int_done = 1'b0;
    chk();
    push("nmi2_req", mk(0, 1, 3, 0, VN, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    int_done = 1'b1; step(); int_done = 1'b0;
    push("no_nmi3", mk(0, 0, 0, 0, VN, 0, 0));
    boundary = 1'b1; step(); boundary = 1'b0;
    chk();
    nmi_n = 1'b1;

    // Asynchronous reset in the middle of servicing an IRQ
    irq_n = 1'b0; p_i = 1'b0;
    repeat (3) step();
    boundary = 1'b1; step(); boundary = 1'b0;
    push("svc_before_reset", mk(0, 0, 1, 0, VI, 0, 1));
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk();
    #2;
    reset = 1'b1;
    #1;
    push("async_reset", mk(1, 0, 0, 1, VR, 0, 0));
    chk();
    irq_n = 1'b1; p_i = 1'b1;
    step();
    reset = 1'b0;
    hold_sequence("rehold");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
